// File: rtl/ddr2_axi_wr_slave.sv
`default_nettype none
// ============================================================================
// ddr2_axi_wr_slave
// AW/W/B write responder: buffers one burst in a FWFT FIFO, then hands a single
// burst request to the DDR2 command scheduler and returns B on completion.
// Revision: 1.0
// ============================================================================
module ddr2_axi_wr_slave #(
  parameter int ROW_BITS   = 13,
  parameter int COL_BITS   = 10,
  parameter int BA_BITS    = 3,
  parameter int DQ_BITS    = 16,
  parameter int ADDR_WIDTH = ROW_BITS + COL_BITS + BA_BITS,
  parameter int DATA_WIDTH = DQ_BITS * 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  ck,
  input  logic                  rst_n,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  wr_req,
  input  logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_len,
  input  logic                  wr_data_rd,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_data_valid,
  input  logic                  wr_done,
  output logic                  len_err
);

  localparam int         PTR_LSB_W = $clog2(FIFO_DEPTH);
  localparam int         PTR_W     = PTR_LSB_W + 1;
  localparam logic [8:0] MAX_LEN   = 9'(FIFO_DEPTH - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DATA      = 3'd1;
  localparam logic [2:0] ISSUE     = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] RESP      = 3'd4;

  logic [2:0]            state_q, state_d;
  logic                  awready_q, awready_d;
  logic                  wr_req_q, wr_req_d;
  logic                  bvalid_q, bvalid_d;
  logic                  len_err_q, len_err_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_len_q, wr_len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            idx_q, idx_d;
  logic                  ovf_q, ovf_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic aw_hs, w_hs, b_hs, final_beat, discard, full, empty, push, pop, flush;

  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Beats past the buffer capacity of an oversized burst are drained, not stored.
  assign discard    = ovf_q && (idx_q > wr_len_q);
  assign final_beat = (cnt_q == 8'd0);
  assign aw_hs      = awvalid && awready_q;
  assign w_hs       = wvalid && wready;
  assign b_hs       = bvalid_q && bready;
  assign push       = w_hs && !discard;
  assign pop        = wr_data_rd && !empty && ((state_q == ISSUE) || (state_q == WAIT_DONE));
  assign flush      = (state_q == WAIT_DONE) && wr_done;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (aw_hs)                state_d = DATA;
      DATA:      if (w_hs && final_beat)   state_d = ISSUE;
      ISSUE:     if (wr_req_q && wr_ack)   state_d = WAIT_DONE;
      WAIT_DONE: if (wr_done)              state_d = RESP;
      RESP:      if (b_hs)                 state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  always_comb begin
    wready    = (state_q == DATA) && (!full || discard);
    awready_d = (state_d == IDLE);
    wr_req_d  = (state_d == ISSUE);
    bvalid_d  = (state_d == RESP);
    len_err_d = w_hs && ((wlast != final_beat) || (final_beat && ovf_q));
  end

  always_comb begin
    wr_addr_d = wr_addr_q;
    wr_len_d  = wr_len_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ovf_d     = ovf_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (aw_hs) begin
      wr_addr_d = awaddr;
      ovf_d     = ({1'b0, awlen} > MAX_LEN);
      wr_len_d  = ovf_d ? MAX_LEN[7:0] : awlen;
      cnt_d     = awlen;
      idx_d     = 8'd0;
    end
    if (w_hs) begin
      cnt_d = cnt_q - 8'd1;
      idx_d = idx_q + 8'd1;
    end
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (flush)    rd_ptr_d = wr_ptr_q;
    else if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      awready_q <= 1'b0;
      wr_req_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      len_err_q <= 1'b0;
      wr_addr_q <= '0;
      wr_len_q  <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      awready_q <= awready_d;
      wr_req_q  <= wr_req_d;
      bvalid_q  <= bvalid_d;
      len_err_q <= len_err_d;
      wr_addr_q <= wr_addr_d;
      wr_len_q  <= wr_len_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only observed through a non-empty head.
  always_ff @(posedge ck) begin
    if (push) mem_q[wr_ptr_q[PTR_W-2:0]] <= wdata;
  end

  assign awready       = awready_q;
  assign bvalid        = bvalid_q;
  assign wr_req        = wr_req_q;
  assign len_err       = len_err_q;
  assign wr_addr       = wr_addr_q;
  assign wr_len        = wr_len_q;
  assign wr_data       = mem_q[rd_ptr_q[PTR_W-2:0]];
  assign wr_data_valid = !empty;

endmodule
`default_nettype wire

// File: tb/tb_ddr2_axi_wr_slave.sv
`default_nettype none
// Testbench for ddr2_axi_wr_slave: directed burst table, randomized bursts
// checked against a beat-level reference model, and a mid-burst reset sequence.
module tb_ddr2_axi_wr_slave;
  localparam int AW    = 26;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          ck = 1'b0;
  logic          rst_n = 1'b0;
  logic          awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
  logic          wr_ack = 1'b0, wr_data_rd = 1'b0, wr_done = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic [DW-1:0] wdata = '0;
  logic          awready, wready, bvalid, wr_req, wr_data_valid, len_err;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_len;
  logic [DW-1:0] wr_data;

  always #5 ck = ~ck;

  ddr2_axi_wr_slave dut (
    .ck(ck), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_data_rd(wr_data_rd), .wr_data(wr_data), .wr_data_valid(wr_data_valid),
    .wr_done(wr_done), .len_err(len_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    logic [255:0]  wl;
    logic [31:0]   base;
    int            gap;
    int            ack_dly;
    int            bready_dly;
    bit            timing;
    int            exp_len;
    int            exp_err;
  } vec_t;

  int n_pass = 0;
  int n_tot = 0;
  int lerr_cnt = 0;
  int ncyc = 0;

  always @(negedge ck) if (rst_n && len_err) lerr_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
    ncyc++;
  endtask

  // Expected len_err pulses: one per beat whose wlast disagrees with its
  // position, plus the final beat of a burst longer than the buffer.
  function automatic int model_err(input int len, input logic [255:0] wl);
    int e = 0;
    for (int i = 0; i <= len; i++) begin
      if (i == len) begin
        if (!wl[i] || (len > DEPTH - 1)) e++;
      end else if (wl[i]) e++;
    end
    return e;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_awready"}, awready, 0);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_bvalid"}, bvalid, 0);
    chk({tag, "_wr_req"}, wr_req, 0);
    chk({tag, "_len_err"}, len_err, 0);
    chk({tag, "_wr_data_valid"}, wr_data_valid, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_len"}, wr_len, 0);
  endtask

  // Called and returns on a negedge. Plays master and scheduler for one burst.
  task automatic do_burst(input logic [AW-1:0] addr, input int len, input logic [255:0] wl,
                          input logic [31:0] base, input int gap, input int ack_dly,
                          input int bready_dly, input bit timing,
                          input int exp_len, input int exp_err);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int i, guard, err0;
    bit hs;
    err0 = lerr_cnt;
    for (int b = 0; b <= len; b++) if (b < DEPTH) exp_q.push_back(base + 32'(b) + 1);

    awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
    guard = 0;
    while (!awready && guard < 100) begin @(negedge ck); guard++; end
    chk("aw_accept", awready, 1);
    ncyc = 0;
    tick();
    awvalid = 1'b0;

    i = 0; guard = 0;
    while (i <= len && guard < 2000) begin
      wvalid = (gap == 0) ? 1'b1 : ($urandom_range(99) >= gap);
      wdata  = base + 32'(i) + 1;
      wlast  = wl[i];
      if (gap != 0) begin
        wr_ack = 1'($urandom_range(1)); wr_done = 1'($urandom_range(1));
        wr_data_rd = 1'($urandom_range(1));
      end
      @(negedge ck);
      if (guard == 0) chk("awready_after_aw", awready, 0);
      chk("wr_req_in_data", wr_req, 0);
      hs = wvalid && wready;
      tick();
      wvalid = 1'b0; wlast = 1'b0; wr_ack = 1'b0; wr_done = 1'b0; wr_data_rd = 1'b0;
      if (hs) i++;
      guard++;
    end
    chk("all_beats_accepted", 64'(i), 64'(len + 1));

    wr_ack = (ack_dly == 0);
    @(negedge ck);
    chk("wr_req_rise", wr_req, 1);
    chk("wr_addr", wr_addr, addr);
    chk("wr_len", wr_len, exp_len);
    chk("wready_in_issue", wready, 0);
    for (int k = 0; k < ack_dly; k++) begin
      tick();
      if (k == ack_dly - 1) wr_ack = 1'b1;
      @(negedge ck);
      chk("wr_req_hold", wr_req, 1);
      chk("awready_in_issue", awready, 0);
    end
    tick();
    wr_ack = 1'b0;

    if (!timing) begin
      wr_data_rd = 1'b1;
      for (int g = 0; g < 300; g++) begin
        @(negedge ck);
        if (!wr_data_valid) break;
        got_q.push_back(wr_data);
        tick();
      end
      tick();
      wr_data_rd = 1'b0;
      @(negedge ck);
      chk("pop_when_empty", wr_data_valid, 0);
      chk("beat_count", 64'(got_q.size()), 64'(exp_q.size()));
      for (int b = 0; b < exp_q.size() && b < got_q.size(); b++)
        chk("wr_data", got_q[b], exp_q[b]);
    end
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;

    bready = (bready_dly == 0);
    @(negedge ck);
    chk("bvalid_rise", bvalid, 1);
    chk("fifo_flushed", wr_data_valid, 0);
    chk("awready_before_b", awready, 0);
    for (int k = 0; k < bready_dly; k++) begin
      tick();
      if (k == bready_dly - 1) bready = 1'b1;
      @(negedge ck);
      chk("bvalid_hold", bvalid, 1);
      chk("awready_before_b", awready, 0);
    end
    tick();
    bready = 1'b0;
    @(negedge ck);
    chk("awready_after_b", awready, 1);
    chk("bvalid_after_b", bvalid, 0);
    if (timing) chk("aw_spacing", 64'(ncyc), 64'(len + 5));
    chk("len_err_pulses", 64'(lerr_cnt - err0), 64'(exp_err));
  endtask

  initial begin
    vec_t vt[11];
    vt[0]  = '{26'h0000100, 7,  256'h80,     32'h000, 0,  0, 0, 1'b0, 7,  0};
    vt[1]  = '{26'h0000200, 7,  256'h80,     32'h100, 0,  0, 0, 1'b1, 7,  0};
    vt[2]  = '{26'h0001234, 5,  256'h20,     32'h200, 50, 3, 5, 1'b0, 5,  0};
    vt[3]  = '{26'h0000400, 3,  256'h0A,     32'h300, 0,  0, 0, 1'b0, 3,  1};
    vt[4]  = '{26'h0000500, 3,  256'h00,     32'h400, 0,  0, 0, 1'b0, 3,  1};
    vt[5]  = '{26'h0000600, 20, 256'h100000, 32'h500, 0,  0, 0, 1'b0, 15, 1};
    vt[6]  = '{26'h0000700, 0,  256'h01,     32'h600, 0,  0, 0, 1'b0, 0,  0};
    vt[7]  = '{26'h0000800, 15, 256'h8000,   32'h700, 0,  0, 0, 1'b0, 15, 0};
    vt[8]  = '{26'h0000900, 15, 256'h8000,   32'h800, 0,  0, 0, 1'b0, 15, 0};
    vt[9]  = '{26'h0000A00, 15, 256'h8000,   32'h900, 0,  0, 0, 1'b0, 15, 0};
    vt[10] = '{26'h0000B00, 15, 256'h8000,   32'hA00, 0,  0, 0, 1'b1, 15, 0};

    repeat (2) @(negedge ck);
    chk_reset_vals("reset");
    @(posedge ck); #1;
    rst_n = 1'b1;
    @(negedge ck);
    chk("awready_before_first_edge", awready, 0);
    @(negedge ck);
    chk("awready_first_edge", awready, 1);

    for (int v = 0; v < 11; v++)
      do_burst(vt[v].addr, vt[v].len, vt[v].wl, vt[v].base, vt[v].gap, vt[v].ack_dly,
               vt[v].bready_dly, vt[v].timing, vt[v].exp_len, vt[v].exp_err);

    for (int r = 0; r < 8; r++) begin
      int len;
      logic [255:0] wl;
      len = int'($urandom_range(24));
      if ($urandom_range(3) == 0) wl = 256'($urandom);
      else begin
        wl = '0;
        wl[len] = 1'b1;
      end
      do_burst(26'($urandom), len, wl, $urandom, 30, int'($urandom_range(3)),
               int'($urandom_range(3)), 1'b0, (len > DEPTH - 1) ? DEPTH - 1 : len,
               model_err(len, wl));
    end

    // Reset in the middle of an 8-beat burst, then a clean 2-beat burst.
    awaddr = 26'h0003ABC; awlen = 8'd7; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      wvalid = 1'b1; wdata = 32'hA0 + 32'(b); wlast = 1'b0;
      tick();
    end
    wvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge ck);
    chk_reset_vals("mid_reset");
    tick();
    @(negedge ck);
    chk("mid_reset_hold_valid", wr_data_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge ck);
    chk("awready_after_mid_reset", awready, 1);
    do_burst(26'h0000C00, 1, 256'h2, 32'hC00, 0, 0, 0, 1'b0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

endmodule
`default_nettype wire
